// File: rtl/spi_readssr_slave.sv
// spi_readssr_slave: oversampled SPI mode-0 slave that fetches one sample per read command and returns status + sample bytes
// Ports: clk/rst_n system clock and async active-low reset; spi_sclk/spi_cs_n/spi_mosi raw SPI pins
// (synchronized here); spi_miso/spi_miso_oe slave data and pad enable; sample_req/sample_ack/sample_data
// level request handshake to the sample source; busy = not idle; frame_count = valid reads (wraps).
module spi_readssr_slave #(
  parameter int DATA_BYTES = 2,
  parameter logic [7:0] CMD_READ = 8'h03,
  parameter logic [7:0] VALID_TOKEN = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic sample_req,
  input  logic sample_ack,
  input  logic [8*DATA_BYTES-1:0] sample_data,
  output logic busy,
  output logic [7:0] frame_count
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = DW + 8;
  localparam logic [2:0] IDLE = 3'd0, CMD = 3'd1, FETCH = 3'd2, SEND = 3'd3, IGNORE = 3'd4;
  logic [1:0] sclk_s, cs_s, mosi_s;
  logic sclk_q, armed, valid;
  logic [2:0] state, bit_cnt;
  logic [7:0] rx;
  logic [DW-1:0] sample;
  logic [TW-1:0] tx;
  logic rise, fall, byte_done, ack_now, valid_n;
  logic [7:0] rx_next;
  logic [DW-1:0] data_n;
  always_comb begin
    rise = sclk_s[1] & ~sclk_q;
    fall = ~sclk_s[1] & sclk_q;
    byte_done = rise && bit_cnt == 3'd7;
    rx_next = {rx[6:0], mosi_s[1]};
    ack_now = sample_req & sample_ack;
    valid_n = valid | ack_now;
    data_n = ack_now ? sample_data : sample;
    busy = state != IDLE;
  end
  // armed blocks a mid-frame join after reset: cs_n must be seen high before a frame can start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      cs_s <= '0;
      mosi_s <= '0;
      sclk_q <= 1'b0;
      armed <= 1'b0;
      state <= IDLE;
      bit_cnt <= '0;
      rx <= '0;
      sample <= '0;
      valid <= 1'b0;
      tx <= '0;
      spi_miso <= 1'b0;
      spi_miso_oe <= 1'b0;
      sample_req <= 1'b0;
      frame_count <= '0;
    end else begin
      sclk_s <= {sclk_s[0], spi_sclk};
      cs_s <= {cs_s[0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
      sclk_q <= sclk_s[1];
      if (cs_s[1]) armed <= 1'b1;
      if (cs_s[1]) begin
        state <= IDLE;
        bit_cnt <= '0;
        rx <= '0;
        valid <= 1'b0;
        spi_miso <= 1'b0;
        spi_miso_oe <= 1'b0;
        sample_req <= 1'b0;
      end else begin
        if (rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          rx <= rx_next;
        end
        case (state)
          IDLE: if (armed) begin
            state <= CMD;
            bit_cnt <= '0;
            rx <= '0;
          end
          CMD: if (byte_done) begin
            state <= rx_next == CMD_READ ? FETCH : IGNORE;
            sample_req <= rx_next == CMD_READ;
            spi_miso_oe <= rx_next == CMD_READ;
            spi_miso <= 1'b0;
          end
          FETCH: begin
            if (ack_now) begin
              sample <= sample_data;
              valid <= 1'b1;
              sample_req <= 1'b0;
            end
            // an ack landing on the byte-done clock still counts via valid_n/data_n
            if (byte_done) begin
              tx <= valid_n ? {VALID_TOKEN, data_n} : '0;
              sample <= data_n;
              valid <= valid_n;
              sample_req <= 1'b0;
              state <= SEND;
              if (valid_n) frame_count <= frame_count + 8'd1;
            end
          end
          SEND: if (fall) begin
            spi_miso <= tx[TW-1];
            tx <= {tx[TW-2:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_readssr_slave.sv
// tb_spi_readssr_slave: table-driven and randomized checks of spi_readssr_slave against a byte-level reference model
module tb_spi_readssr_slave;
  localparam int DB = 2;
  localparam int HALF = 50;
  typedef struct {
    logic [7:0] cmd;
    int d;
    logic [15:0] data;
    int nb;
    int lastbits;
    bit valid;
  } vec_t;
  logic clk = 0, rst_n = 0, spi_sclk = 0, spi_cs_n = 1, spi_mosi = 0, sample_ack = 0;
  logic [15:0] sample_data = 0;
  logic spi_miso, spi_miso_oe, sample_req, busy;
  logic [7:0] frame_count;
  int compared = 0, mismatched = 0;
  int ack_delay = -1, cnt = -1, count_exp = 0;
  logic [15:0] cur_data = 0;
  logic req_d = 0, req_ever = 0;
  logic [7:0] got [16];
  logic oe_all, oe_any, busy_before, busy_after, req_end, req_after;
  vec_t tbl [8];
  spi_readssr_slave #(.DATA_BYTES(DB), .CMD_READ(8'h03), .VALID_TOKEN(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .sample_req(sample_req), .sample_ack(sample_ack),
    .sample_data(sample_data), .busy(busy), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    sample_ack = 0;
    if (sample_req && !req_d && ack_delay > 0) cnt = ack_delay;
    else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) sample_ack = 1;
    end
    sample_data = sample_ack ? cur_data : 16'($urandom);
    req_d = sample_req;
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (sample_req) req_ever = 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] exp_byte(input bit valid, input logic [15:0] data, input int k);
    if (!valid || k == 0 || k > DB + 1) return 8'h00;
    if (k == 1) return 8'hA5;
    return 8'(data >> (8 * (DB + 1 - k)));
  endfunction
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit after_cmd, output logic [7:0] mi);
    mi = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = mo[i];
      #HALF;
      spi_sclk = 1;
      mi[i] = spi_miso;
      if (after_cmd) oe_all &= spi_miso_oe;
      oe_any |= spi_miso_oe;
      #HALF;
      spi_sclk = 0;
    end
  endtask
  task automatic frame(input logic [7:0] cmd, input int nb, input int lastbits);
    logic [7:0] b;
    req_ever = 0;
    oe_all = 1;
    oe_any = 0;
    @(negedge clk);
    #2;
    spi_cs_n = 0;
    #(2 * HALF);
    xfer(cmd, 8, 0, b);
    for (int k = 0; k < nb; k++) xfer(8'($urandom), (k == nb - 1) ? lastbits : 8, 1, got[k]);
    #HALF;
    busy_before = busy;
    req_end = sample_req;
    spi_cs_n = 1;
    #28;
    busy_after = busy;
    req_after = sample_req;
    #(4 * HALF - 28);
  endtask
  task automatic check_frame(input string nm, input vec_t v);
    if (v.cmd == 8'h03) begin
      if (v.lastbits == 8) for (int k = 0; k < v.nb; k++) chk($sformatf("%s byte%0d", nm, k), got[k], exp_byte(v.valid, v.data, k));
      chk({nm, " oe"}, oe_all, 1);
      if (v.nb > 1) chk({nm, " req_end"}, req_end, 0);
      if (v.valid) count_exp = (count_exp + 1) % 256;
    end else begin
      chk({nm, " oe_any"}, oe_any, 0);
      chk({nm, " req_ever"}, req_ever, 0);
    end
    chk({nm, " busy_before"}, busy_before, 1);
    chk({nm, " busy_after"}, busy_after, 0);
    chk({nm, " req_after"}, req_after, 0);
    chk({nm, " count"}, frame_count, count_exp);
  endtask
  initial begin
    vec_t v;
    logic [7:0] b;
    int r;
    tbl[0] = '{8'h03, 3, 16'hBEEF, 4, 8, 1'b1};
    tbl[1] = '{8'h03, -1, 16'h0000, 4, 8, 1'b0};
    tbl[2] = '{8'h03, 120, 16'h1111, 5, 8, 1'b0};
    tbl[3] = '{8'h55, 3, 16'h2222, 3, 8, 1'b0};
    tbl[4] = '{8'h03, -1, 16'h0000, 1, 4, 1'b0};
    tbl[5] = '{8'h03, 7, 16'h1234, 4, 8, 1'b1};
    tbl[6] = '{8'h03, 4, 16'hA1B2, 9, 8, 1'b1};
    tbl[7] = '{8'h03, 20, 16'hC3D4, 9, 8, 1'b1};
    #20;
    chk("rst miso", spi_miso, 0);
    chk("rst oe", spi_miso_oe, 0);
    chk("rst req", sample_req, 0);
    chk("rst busy", busy, 0);
    chk("rst count", frame_count, 0);
    rst_n = 1;
    #100;
    for (int i = 0; i < 8; i++) begin
      ack_delay = tbl[i].d;
      cur_data = tbl[i].data;
      frame(tbl[i].cmd, tbl[i].nb, tbl[i].lastbits);
      check_frame($sformatf("vec%0d", i), tbl[i]);
    end
    for (int i = 0; i < 20; i++) begin
      v.cmd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h03;
      r = $urandom_range(0, 2);
      v.d = r == 0 ? -1 : r == 1 ? $urandom_range(1, 60) : $urandom_range(100, 150);
      v.data = 16'($urandom);
      v.nb = $urandom_range(3, 6);
      v.lastbits = 8;
      v.valid = v.cmd == 8'h03 && v.d >= 1 && v.d <= 60;
      ack_delay = v.d;
      cur_data = v.data;
      frame(v.cmd, v.nb, v.lastbits);
      check_frame($sformatf("rnd%0d", i), v);
    end
    ack_delay = 5;
    cur_data = 16'hCAFE;
    oe_all = 1;
    oe_any = 0;
    @(negedge clk);
    #2;
    spi_cs_n = 0;
    #(2 * HALF);
    xfer(8'h03, 8, 0, b);
    xfer(8'h00, 8, 1, b);
    xfer(8'h00, 4, 1, b);
    chk("midsend oe", spi_miso_oe, 1);
    chk("midsend count", frame_count, 8'(count_exp + 1));
    rst_n = 0;
    #1;
    chk("async miso", spi_miso, 0);
    chk("async oe", spi_miso_oe, 0);
    chk("async req", sample_req, 0);
    chk("async busy", busy, 0);
    chk("async count", frame_count, 0);
    count_exp = 0;
    #(HALF - 1);
    rst_n = 1;
    oe_any = 0;
    xfer(8'h00, 4, 1, b);
    xfer(8'h03, 8, 1, b);
    xfer(8'h00, 8, 1, b);
    chk("nojoin busy", busy, 0);
    chk("nojoin oe", oe_any, 0);
    #HALF;
    spi_cs_n = 1;
    #(4 * HALF);
    v = '{8'h03, 9, 16'h5A3C, 4, 8, 1'b1};
    ack_delay = v.d;
    cur_data = v.data;
    frame(v.cmd, v.nb, v.lastbits);
    check_frame("recover", v);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
